macro_id_monitor: RTL and testbench
===================================

Name: macro_id_monitor

Overview:
- Receive-side counterpart of the per-tile identity macro in the 2x2 grid. That macro drives a one-hot pattern, indexed by its tile number, on its east, west and north IO buses.
- This block samples those buses from the pad side, synchronises them and waits for the pattern to settle. It then reports which macro is driving, or flags a malformed or disagreeing pattern.
- It sits in the harness/test tile, next to the pad ring inputs.

Parameters:
- EAST_W, 14, width of east IO bus
- WEST_W, 14, width of west IO bus
- NORTH_W, 10, width of north IO bus
- NUM_MACROS, 9, number of valid macro indices (0..NUM_MACROS-1); must be <= NORTH_W
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before classification; range 1..15

Ports:
- clk  input  1  block clock
- rst_n  input  1  synchronous reset, active-low
- IO_east_i  input  EAST_W  east pad inputs, asynchronous
- IO_west_i  input  WEST_W  west pad inputs, asynchronous
- IO_north_i  input  NORTH_W  north pad inputs, asynchronous
- clr_i  input  1  clears fault_sticky_o and lock_count_o
- state_o  output  2  0=IDLE, 1=ACQUIRE, 2=LOCKED, 3=FAULT
- id_o  output  4  decoded macro index; valid only when id_valid_o=1
- id_valid_o  output  1  high only in LOCKED
- fault_side_o  output  3  {north,west,east}; per-side invalid or disagreeing flag, latched at FAULT entry
- fault_sticky_o  output  1  set on any FAULT entry, held until clr_i
- lock_count_o  output  8  saturating count of LOCKED entries

Behaviour:
- Reset (rst_n=0 at a clk edge): all synchroniser flops 0, stable counter 0, state ACQUIRE, id_o=0, id_valid_o=0, fault_side_o=0, fault_sticky_o=0, lock_count_o=0.
- Synchroniser: 2-flop synchroniser on all EAST_W+WEST_W+NORTH_W bits; the output is the "sample".
- Sample history: the previous sample is held in a register.
- Stable counter, 4 bits:
  - Sample != previous sample: counter <= 1, state <= ACQUIRE, id_valid_o <= 0, all on the same edge.
  - Sample == previous sample: counter increments, saturating at STABLE_CYCLES.
- Classification: occurs on the edge where the counter transitions to STABLE_CYCLES, and only once per stable run.
  - Side valid: exactly one bit set, bit index < NUM_MACROS, all other bits of that side 0.
  - All three sides zero: IDLE.
  - All sides valid with equal index: LOCKED; id_o <= index; id_valid_o <= 1; lock_count_o increments (saturates at 255).
  - Otherwise: FAULT; fault_sticky_o <= 1.
- fault_side_o at FAULT entry:
  - A bit is set if its side is invalid.
  - If all sides are individually valid but indices disagree, the bits set are those sides whose index differs from the north index. If only north differs, the bits are {east,west}.
- fault_side_o outside FAULT: holds its last value; cleared on the next LOCKED entry.
- State transitions:
  - ACQUIRE -> {IDLE, LOCKED, FAULT} only via classification.
  - IDLE, LOCKED or FAULT -> ACQUIRE on any sample change.
  - There is no direct transition between IDLE, LOCKED and FAULT.
- Latency: pad change held steady from edge 0 -> state_o/id_valid_o updated after edge 2+STABLE_CYCLES, i.e. 6 edges at default.
- Glitch filtering: a change lasting fewer than STABLE_CYCLES synchronised samples never produces FAULT or LOCKED. It only causes ACQUIRE.
- clr_i:
  - Clears fault_sticky_o and lock_count_o on the next edge.
  - If a FAULT entry coincides with clr_i, the set wins: fault_sticky_o=1.
  - If a LOCKED entry coincides with clr_i, lock_count_o=1.
- Reset mid-operation: returns to the reset values above on the next edge. The synchroniser is also flushed.
- Index width: id_o is fixed at 4 bits. Indices up to 15 are supported; NUM_MACROS must be <= 16.

Decomposition:
- Shared package macro_mon_pkg:
  - state enum (IDLE/ACQUIRE/LOCKED/FAULT, 2 bits)
  - ID_W=4
  - default bus widths 14/14/10
- Sub-module onehot_side_check:
  - Parameters: W, NUM_MACROS.
  - Inputs: a vector.
  - Outputs: valid, zero, 4-bit index.
  - Purely combinational; instantiated 3x.

Test Plan:
- Reset, then drive 0x0001/0x0001/0x001 (macro 0) steady -> ACQUIRE, then LOCKED after edge 6; id_o=0; id_valid_o=1; lock_count_o=1.
- Switch to macro 5 (0x0020 on all sides) -> id_valid_o=0 on the edge the new sample arrives; LOCKED with id_o=5 four samples later; lock_count_o=2.
- East=0x0003, west/north=macro 2 -> FAULT; fault_side_o=3'b001; fault_sticky_o=1; id_valid_o=0. Then pulse clr_i -> fault_sticky_o=0.
- East/west=macro 1, north=macro 3 -> FAULT, fault_side_o=3'b011. Also drive bit 9 on all sides (index 9 >= NUM_MACROS) -> FAULT, fault_side_o=3'b111.
- From macro-4 LOCKED, inject a 2-cycle glitch to 0x0000 -> ACQUIRE only, no FAULT and no IDLE. Relocks to id 4 with lock_count_o incremented. All inputs 0 steady -> IDLE.
- Assert rst_n=0 for one edge while LOCKED -> all outputs at reset values. LOCKED again 6 edges after release.

Source files
------------

// File: rtl/macro_mon_pkg.sv
// ---------------------------------------------------------------------------
// macro_mon_pkg
//   Shared types and constants for the macro identity monitor.
//   - mon_state_e : reported monitor state (IDLE/ACQUIRE/LOCKED/FAULT)
//   - side_chk_t  : per-bus one-hot check result (valid, zero, index)
//   - ID_W        : width of a decoded macro index
//   - DEF_*_W     : default pad bus widths of the identity macro
// ---------------------------------------------------------------------------
package macro_mon_pkg;

  localparam int ID_W        = 4;
  localparam int DEF_EAST_W  = 14;
  localparam int DEF_WEST_W  = 14;
  localparam int DEF_NORTH_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } mon_state_e;

  typedef struct packed {
    logic            valid;
    logic            zero;
    logic [ID_W-1:0] index;
  } side_chk_t;

endpackage

// File: rtl/macro_id_monitor_side_check.sv
// ---------------------------------------------------------------------------
// onehot_side_check
//   Combinational check of one identity bus. A bus is valid when exactly one
//   bit is set and that bit addresses an existing macro (< NUM_MACROS).
//   Ports:
//     i_vec    in  W     synchronised bus sample
//     o_valid  out 1     exactly one legal bit set
//     o_zero   out 1     bus is all zero
//     o_index  out ID_W  position of the set bit (meaningful when o_valid)
// ---------------------------------------------------------------------------
module onehot_side_check
  import macro_mon_pkg::*;
#(
  parameter int W          = 14,
  parameter int NUM_MACROS = 9
) (
  input  logic [W-1:0]    i_vec,
  output logic            o_valid,
  output logic            o_zero,
  output logic [ID_W-1:0] o_index
);

  localparam int CW = $clog2(W + 1);
  // Bits that may legally carry the one-hot marker.
  localparam logic [W-1:0] LEGAL = W'((64'd1 << NUM_MACROS) - 64'd1);

  logic [CW-1:0]   w_cnt;
  logic [ID_W-1:0] w_idx;

  // Population count plus position of the highest set bit; the position is
  // only used when the count is exactly one, so "highest" is unambiguous.
  always_comb begin
    w_cnt = '0;
    w_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) begin
        w_cnt = w_cnt + CW'(1);
        w_idx = ID_W'(i);
      end
    end
  end

  assign o_zero  = (i_vec == '0);
  assign o_valid = (w_cnt == CW'(1)) && ((i_vec & ~LEGAL) == '0);
  assign o_index = w_idx;

endmodule

// File: rtl/macro_id_monitor.sv
// ---------------------------------------------------------------------------
// macro_id_monitor
//   Pad-side receiver for the per-tile identity macro. Synchronises the east,
//   west and north identity buses, waits for STABLE_CYCLES identical samples
//   and classifies the pattern once per stable run:
//     all zero                  -> IDLE
//     all one-hot, same index   -> LOCKED (id_o valid)
//     anything else             -> FAULT  (fault_side_o says which sides)
//   Any sample change drops back to ACQUIRE.
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     IO_east_i        EAST_W  asynchronous east pad inputs
//     IO_west_i        WEST_W  asynchronous west pad inputs
//     IO_north_i       NORTH_W asynchronous north pad inputs
//     clr_i            clears fault_sticky_o and lock_count_o
//     state_o          0=IDLE 1=ACQUIRE 2=LOCKED 3=FAULT
//     id_o             decoded macro index (valid with id_valid_o)
//     id_valid_o       high only in LOCKED
//     fault_side_o     {north,west,east} fault flags, latched at FAULT entry
//     fault_sticky_o   set on any FAULT entry until clr_i
//     lock_count_o     saturating count of LOCKED entries
//   NUM_MACROS must be <= min(NORTH_W,16); STABLE_CYCLES in 1..15.
// ---------------------------------------------------------------------------
module macro_id_monitor
  import macro_mon_pkg::*;
#(
  parameter int EAST_W        = DEF_EAST_W,
  parameter int WEST_W        = DEF_WEST_W,
  parameter int NORTH_W       = DEF_NORTH_W,
  parameter int NUM_MACROS    = 9,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [EAST_W-1:0]  IO_east_i,
  input  logic [WEST_W-1:0]  IO_west_i,
  input  logic [NORTH_W-1:0] IO_north_i,
  input  logic               clr_i,
  output logic [1:0]         state_o,
  output logic [ID_W-1:0]    id_o,
  output logic               id_valid_o,
  output logic [2:0]         fault_side_o,
  output logic               fault_sticky_o,
  output logic [7:0]         lock_count_o
);

  localparam int         TOT_W  = EAST_W + WEST_W + NORTH_W;
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  // Synchroniser and sample history; bus order is {north, west, east}.
  logic [TOT_W-1:0] r_sync1;
  logic [TOT_W-1:0] r_sync2;
  logic [TOT_W-1:0] r_prev;

  logic [3:0]      r_cnt;
  logic            r_done;      // current stable run already classified
  mon_state_e      r_state;
  logic [ID_W-1:0] r_id;
  logic            r_id_valid;
  logic [2:0]      r_fault_side;
  logic            r_sticky;
  logic [7:0]      r_lock_cnt;

  logic [EAST_W-1:0]  w_east;
  logic [WEST_W-1:0]  w_west;
  logic [NORTH_W-1:0] w_north;
  side_chk_t          w_e;
  side_chk_t          w_w;
  side_chk_t          w_n;

  logic       w_changed;
  logic [3:0] w_cnt_nxt;
  logic       w_classify;
  logic       w_all_zero;
  logic       w_all_valid;
  logic       w_agree;
  logic       w_lock;
  logic [2:0] w_fault_side;

  assign w_east  = r_sync2[EAST_W-1:0];
  assign w_west  = r_sync2[EAST_W +: WEST_W];
  assign w_north = r_sync2[EAST_W+WEST_W +: NORTH_W];

  onehot_side_check #(.W(EAST_W), .NUM_MACROS(NUM_MACROS)) u_chk_east (
    .i_vec   (w_east),
    .o_valid (w_e.valid),
    .o_zero  (w_e.zero),
    .o_index (w_e.index)
  );

  onehot_side_check #(.W(WEST_W), .NUM_MACROS(NUM_MACROS)) u_chk_west (
    .i_vec   (w_west),
    .o_valid (w_w.valid),
    .o_zero  (w_w.zero),
    .o_index (w_w.index)
  );

  onehot_side_check #(.W(NORTH_W), .NUM_MACROS(NUM_MACROS)) u_chk_north (
    .i_vec   (w_north),
    .o_valid (w_n.valid),
    .o_zero  (w_n.zero),
    .o_index (w_n.index)
  );

  assign w_changed = (r_sync2 != r_prev);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_changed)             w_cnt_nxt = 4'd1;
    else if (r_cnt != STABLE)  w_cnt_nxt = r_cnt + 4'd1;
  end

  // r_done makes classification one-shot per run; it also lets a run of
  // length one (STABLE_CYCLES=1) classify on the first repeat of a sample.
  assign w_classify = !w_changed && !r_done && (w_cnt_nxt == STABLE);

  assign w_all_zero  = w_e.zero  & w_w.zero  & w_n.zero;
  assign w_all_valid = w_e.valid & w_w.valid & w_n.valid;
  assign w_agree     = (w_e.index == w_n.index) && (w_w.index == w_n.index);
  assign w_lock      = w_all_valid && w_agree;

  // Malformed sides take priority; otherwise north is the reference index,
  // so a lone north mismatch flags both east and west.
  always_comb begin
    if (!w_all_valid)
      w_fault_side = {~w_n.valid, ~w_w.valid, ~w_e.valid};
    else
      w_fault_side = {1'b0, (w_w.index != w_n.index), (w_e.index != w_n.index)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_prev       <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_state      <= ST_ACQUIRE;
      r_id         <= '0;
      r_id_valid   <= 1'b0;
      r_fault_side <= '0;
      r_sticky     <= 1'b0;
      r_lock_cnt   <= '0;
    end else begin
      r_sync1 <= {IO_north_i, IO_west_i, IO_east_i};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_cnt   <= w_cnt_nxt;

      if (clr_i) begin
        r_sticky   <= 1'b0;
        r_lock_cnt <= '0;
      end

      if (w_changed) begin
        r_state    <= ST_ACQUIRE;
        r_id_valid <= 1'b0;
        r_done     <= 1'b0;
      end else if (w_classify) begin
        r_done <= 1'b1;
        if (w_all_zero) begin
          r_state <= ST_IDLE;
        end else if (w_lock) begin
          r_state      <= ST_LOCKED;
          r_id         <= w_n.index;
          r_id_valid   <= 1'b1;
          r_fault_side <= '0;
          // A coincident clear restarts the count at this entry.
          if (clr_i)                    r_lock_cnt <= 8'd1;
          else if (r_lock_cnt != 8'hFF) r_lock_cnt <= r_lock_cnt + 8'd1;
        end else begin
          r_state      <= ST_FAULT;
          r_fault_side <= w_fault_side;
          r_sticky     <= 1'b1;
        end
      end
    end
  end

  assign state_o        = r_state;
  assign id_o           = r_id;
  assign id_valid_o     = r_id_valid;
  assign fault_side_o   = r_fault_side;
  assign fault_sticky_o = r_sticky;
  assign lock_count_o   = r_lock_cnt;

endmodule

// File: tb/tb_macro_id_monitor.sv
module tb_macro_id_monitor;

  localparam int EW = 14;
  localparam int WW = 14;
  localparam int NW = 10;
  localparam int NM = 9;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic [EW-1:0] pe;
  logic [WW-1:0] pw;
  logic [NW-1:0] pn;
  logic [1:0]    state_o;
  logic [3:0]    id_o;
  logic          id_valid_o;
  logic [2:0]    fault_side_o;
  logic          fault_sticky_o;
  logic [7:0]    lock_count_o;

  int checks   = 0;
  int failures = 0;

  macro_id_monitor #(
    .EAST_W(EW), .WEST_W(WW), .NORTH_W(NW), .NUM_MACROS(NM), .STABLE_CYCLES(SC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IO_east_i      (pe),
    .IO_west_i      (pw),
    .IO_north_i     (pn),
    .clr_i          (clr),
    .state_o        (state_o),
    .id_o           (id_o),
    .id_valid_o     (id_valid_o),
    .fault_side_o   (fault_side_o),
    .fault_sticky_o (fault_sticky_o),
    .lock_count_o   (lock_count_o)
  );

  always #5 clk = ~clk;

  // Reference model: what the monitor examines at each edge is the pad value
  // from two edges earlier; a run is the span of edges since the examined
  // value last changed (or since reset). Classification fires when a run
  // reaches exactly SC edges.
  logic [37:0] m_pipe[$];
  logic [37:0] m_prevd;
  int          m_edge, m_run_start, m_cnt;
  logic [1:0]  m_state;
  logic [3:0]  m_id;
  logic        m_valid, m_sticky;
  logic [2:0]  m_fs;

  function automatic logic [4:0] side(input logic [15:0] v);
    logic ok;
    ok = ($countones(v) == 1) && (v < (16'd1 << NM));
    return {ok, ok ? 4'($clog2(v)) : 4'd0};
  endfunction

  task automatic classify(input logic [37:0] d);
    logic [4:0] se, sw, sn;
    se = side(16'(d[13:0]));
    sw = side(16'(d[27:14]));
    sn = side(16'(d[37:28]));
    if (d == '0) begin
      m_state = 2'd0;
    end else if (se[4] && sw[4] && sn[4] && se[3:0] == sn[3:0] && sw[3:0] == sn[3:0]) begin
      m_state = 2'd2; m_id = sn[3:0]; m_valid = 1'b1; m_fs = 3'b000;
      m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
    end else begin
      m_state = 2'd3; m_sticky = 1'b1;
      if (!(se[4] && sw[4] && sn[4])) m_fs = {!sn[4], !sw[4], !se[4]};
      else m_fs = {1'b0, sw[3:0] != sn[3:0], se[3:0] != sn[3:0]};
    end
  endtask

  task automatic model_edge();
    logic [37:0] d;
    if (!rst_n) begin
      m_pipe.delete(); m_pipe.push_back('0); m_pipe.push_back('0);
      m_edge = 0; m_run_start = 0; m_prevd = '0;
      m_state = 2'd1; m_id = 0; m_valid = 0; m_fs = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      d = m_pipe.pop_front();
      m_pipe.push_back({pn, pw, pe});
      m_edge++;
      if (m_edge == 1) m_run_start = 1;
      else if (d != m_prevd) begin
        m_run_start = m_edge; m_state = 2'd1; m_valid = 1'b0;
      end
      m_prevd = d;
      if (clr) begin m_sticky = 1'b0; m_cnt = 0; end
      if (m_edge - m_run_start + 1 == SC) classify(d);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("state",   32'(state_o),        32'(m_state));
    chk("id_vld",  32'(id_valid_o),     32'(m_valid));
    chk("fside",   32'(fault_side_o),   32'(m_fs));
    chk("sticky",  32'(fault_sticky_o), 32'(m_sticky));
    chk("lockcnt", 32'(lock_count_o),   32'(m_cnt));
    if (m_valid) chk("id", 32'(id_o), 32'(m_id));
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [15:0] e, input logic [15:0] w, input logic [15:0] n);
    pe = EW'(e); pw = WW'(w); pn = NW'(n);
  endtask

  task automatic pulse_clr_tick();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  initial begin
    logic [15:0] e, w, n, m;
    rst_n = 1'b0; clr = 1'b0; drive(0, 0, 0);

    // Reset state
    tick();
    chk("rst_state", 32'(state_o), 32'd1);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_cnt", 32'(lock_count_o), 32'd0);

    // Macro 0: locked exactly after the sixth edge
    rst_n = 1'b1; drive(16'h1, 16'h1, 16'h1);
    hold(5);
    chk("lat_acq", 32'(state_o), 32'd1);
    tick();
    chk("m0_state", 32'(state_o), 32'd2);
    chk("m0_id", 32'(id_o), 32'd0);
    chk("m0_cnt", 32'(lock_count_o), 32'd1);

    // Macro 5: valid drops when the new sample is first seen
    drive(16'h20, 16'h20, 16'h20);
    hold(2);
    chk("m5_still", 32'(id_valid_o), 32'd1);
    tick();
    chk("m5_drop", 32'(id_valid_o), 32'd0);
    hold(3);
    chk("m5_id", 32'(id_o), 32'd5);
    chk("m5_cnt", 32'(lock_count_o), 32'd2);

    // Malformed east side, then clear the sticky flag
    drive(16'h3, 16'h4, 16'h4);
    hold(6);
    chk("fe_state", 32'(state_o), 32'd3);
    chk("fe_side", 32'(fault_side_o), 32'b001);
    chk("fe_sticky", 32'(fault_sticky_o), 32'd1);
    pulse_clr_tick();
    chk("clr_sticky", 32'(fault_sticky_o), 32'd0);

    // Disagreeing north, then out-of-range index on all sides
    drive(16'h2, 16'h2, 16'h8);
    hold(6);
    chk("fn_side", 32'(fault_side_o), 32'b011);
    drive(16'h200, 16'h200, 16'h200);
    hold(6);
    chk("f9_side", 32'(fault_side_o), 32'b111);

    // Macro 4, two-cycle glitch, relock, then idle
    drive(16'h10, 16'h10, 16'h10);
    hold(6);
    chk("m4_id", 32'(id_o), 32'd4);
    chk("m4_fside", 32'(fault_side_o), 32'd0);
    drive(0, 0, 0);
    hold(2);
    drive(16'h10, 16'h10, 16'h10);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_noclass", 32'(state_o == 2'd1 || state_o == 2'd2), 32'd1);
    end
    chk("relock_id", 32'(id_o), 32'd4);
    chk("relock_cnt", 32'(lock_count_o), 32'd2);
    drive(0, 0, 0);
    hold(6);
    chk("idle", 32'(state_o), 32'd0);

    // Reset while locked
    drive(16'h80, 16'h80, 16'h80);
    hold(6);
    rst_n = 1'b0;
    tick();
    chk("mrst_state", 32'(state_o), 32'd1);
    chk("mrst_cnt", 32'(lock_count_o), 32'd0);
    rst_n = 1'b1;
    hold(5);
    chk("mrst_acq", 32'(state_o), 32'd1);
    tick();
    chk("mrst_lock", 32'(id_o), 32'd7);

    // Clear coinciding with a LOCKED entry and with a FAULT entry
    drive(16'h8, 16'h8, 16'h8);
    hold(5);
    pulse_clr_tick();
    chk("clr_lock_cnt", 32'(lock_count_o), 32'd1);
    drive(16'h3, 16'h8, 16'h8);
    hold(5);
    pulse_clr_tick();
    chk("clr_fault_sticky", 32'(fault_sticky_o), 32'd1);

    // Lock counter saturation
    for (int i = 0; i < 260; i++) begin
      m = (i % 2 == 0) ? 16'h2 : 16'h4;
      drive(m, m, m);
      hold(6);
    end
    chk("cnt_sat", 32'(lock_count_o), 32'd255);

    // Randomised patterns with random hold lengths and clear pulses
    for (int s = 0; s < 200; s++) begin
      int k;
      k = $urandom_range(0, 9);
      m = 16'd1 << $urandom_range(0, NM - 1);
      e = m; w = m; n = m;
      case (k)
        5: begin e = 0; w = 0; n = 0; end
        6: begin
          case ($urandom_range(0, 2))
            0: e = 16'd1 << $urandom_range(0, NM - 1);
            1: w = 16'd1 << $urandom_range(0, NM - 1);
            default: n = 16'd1 << $urandom_range(0, NM - 1);
          endcase
        end
        7: e = e | 16'($urandom);
        8: begin e = 16'($urandom); w = 16'($urandom); n = 16'($urandom); end
        9: begin e = 16'h200; w = 16'h2000; n = 16'h200; end
        default: ;
      endcase
      drive(e, w, n);
      for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
        clr = ($urandom_range(0, 7) == 0);
        tick();
      end
      clr = 1'b0;
    end
    hold(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
